// File: rtl/fx2_pkg.sv
// rtl/fx2_pkg.sv - shared state, frame layout and checksum helper for the FX2 command framer
package fx2_pkg;

    localparam int FRAME_BYTES = 8;

    localparam int ADDR0     = 0;
    localparam int ADDR1     = 1;
    localparam int ADDR2     = 2;
    localparam int BURST_LEN = 3;
    localparam int DATA0     = 4;
    localparam int DATA1     = 5;
    localparam int FLAGS     = 6;
    localparam int CSUM      = 7;

    localparam int FLAG_RDWR = 0;
    localparam int FLAG_CMD  = 1;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_CHECK   = 2'd1,
        ST_ISSUE   = 2'd2
    } fx2_state_t;

    typedef logic [FRAME_BYTES-1:0][7:0] fx2_frame_t;

    // XOR of every byte that precedes the checksum slot
    function automatic logic [7:0] frame_csum(input fx2_frame_t f);
        logic [7:0] x;
        x = 8'h00;
        for (int i = 0; i < CSUM; i++) begin
            x = x ^ f[i];
        end
        return x;
    endfunction

endpackage

// File: rtl/fx2_cmd_framer_if.sv
// rtl/fx2_cmd_framer_if.sv - memory request channel from the framer to the SDRAM controller
interface fx2_cmd_framer_if;

    logic        req_valid;
    logic        req_ready;
    logic [23:0] req_addr;
    logic [15:0] req_data;
    logic        req_rdwr;
    logic        req_cmd;

    modport master (
        output req_valid,
        output req_addr,
        output req_data,
        output req_rdwr,
        output req_cmd,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        input  req_data,
        input  req_rdwr,
        input  req_cmd,
        output req_ready
    );

endinterface

// File: rtl/fx2_byte_timer.sv
// rtl/fx2_byte_timer.sv - idle-gap counter that expires after TIMEOUT_CYCLES cycles without a byte
module fx2_byte_timer #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] count;

    // Fires once the count has reached the limit, independent of this cycle's byte
    assign expire = enable && (count == CW'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear || expire || !enable) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/fx2_cmd_framer.sv
// rtl/fx2_cmd_framer.sv - collects 8-byte FX2 command frames, validates them and issues memory bursts
module fx2_cmd_framer
    import fx2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     fifo_data_available,
    input  logic [7:0]               fifo_datain,
    output logic                     fifo_rd,
    fx2_cmd_framer_if.master         req,
    output logic                     frame_err,
    output logic [7:0]               err_count
);

    localparam int IW = $clog2(FRAME_BYTES);

    fx2_state_t     state;
    fx2_state_t     state_nxt;
    logic [IW-1:0]  idx;
    fx2_frame_t     frame;
    logic [7:0]     remaining;
    logic [23:0]    addr_q;
    logic [15:0]    data_q;
    logic           rdwr_q;
    logic           cmd_q;
    logic           valid_c;
    logic           timeout;
    logic           timer_en;
    logic           csum_ok;
    logic           xfer;
    logic           last_xfer;
    logic           frame_done;

    assign csum_ok    = (frame_csum(frame) == frame[CSUM]);
    assign xfer       = valid_c && req.req_ready;
    assign last_xfer  = xfer && (remaining == 8'd0);
    assign timer_en   = (state == ST_COLLECT) && (idx != '0);
    // A byte that lands on the timeout cycle restarts the frame, so it never completes one
    assign frame_done = fifo_rd && !timeout && (idx == IW'(FRAME_BYTES - 1));

    fx2_byte_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_byte_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (fifo_rd),
        .enable (timer_en),
        .expire (timeout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_COLLECT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_COLLECT: if (frame_done) state_nxt = ST_CHECK;
            ST_CHECK:   state_nxt = csum_ok ? ST_ISSUE : ST_COLLECT;
            ST_ISSUE:   if (last_xfer) state_nxt = ST_COLLECT;
            default:    state_nxt = ST_COLLECT;
        endcase
    end

    // fifo_rd is gated by rst so the strobe drops the instant reset rises
    always_comb begin
        fifo_rd   = 1'b0;
        valid_c   = 1'b0;
        frame_err = 1'b0;
        case (state)
            ST_COLLECT: begin
                fifo_rd   = fifo_data_available && !rst;
                frame_err = timeout;
            end
            ST_CHECK:   frame_err = !csum_ok;
            ST_ISSUE:   valid_c   = 1'b1;
            default:    ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx       <= '0;
            frame     <= '0;
            remaining <= 8'd0;
            addr_q    <= 24'd0;
            data_q    <= 16'd0;
            rdwr_q    <= 1'b0;
            cmd_q     <= 1'b0;
            err_count <= 8'd0;
        end else begin
            if (fifo_rd) begin
                if (timeout) begin
                    frame[0] <= fifo_datain;
                    idx      <= IW'(1);
                end else begin
                    frame[idx] <= fifo_datain;
                    idx        <= idx + 1'b1;
                end
            end else if (timeout) begin
                idx <= '0;
            end

            if (frame_err && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end

            if ((state == ST_CHECK) && csum_ok) begin
                addr_q    <= {frame[ADDR2], frame[ADDR1], frame[ADDR0]};
                data_q    <= {frame[DATA1], frame[DATA0]};
                rdwr_q    <= frame[FLAGS][FLAG_RDWR];
                cmd_q     <= frame[FLAGS][FLAG_CMD];
                // Command frames are a single request regardless of the burst byte
                remaining <= frame[FLAGS][FLAG_CMD] ? 8'd0 : frame[BURST_LEN];
            end else if (xfer && (remaining != 8'd0)) begin
                remaining <= remaining - 8'd1;
                addr_q    <= addr_q + 24'd1;
            end
        end
    end

    assign req.req_valid = valid_c;
    assign req.req_addr  = addr_q;
    assign req.req_data  = data_q;
    assign req.req_rdwr  = rdwr_q;
    assign req.req_cmd   = cmd_q;

endmodule

// File: tb/tb_fx2_cmd_framer.sv
// tb/tb_fx2_cmd_framer.sv - directed table-driven bench for fx2_cmd_framer
module tb_fx2_cmd_framer;
    import fx2_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       dav = 1'b0;
    logic [7:0] datain = 8'h00;
    logic       fifo_rd;
    logic       frame_err;
    logic [7:0] err_count;

    int n_tests = 0;
    int n_fail  = 0;
    int rd_miss = 0;

    fx2_cmd_framer_if bus ();

    fx2_cmd_framer dut (
        .clk                 (clk),
        .rst                 (rst),
        .fifo_data_available (dav),
        .fifo_datain         (datain),
        .fifo_rd             (fifo_rd),
        .req                 (bus),
        .frame_err           (frame_err),
        .err_count           (err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] addr;
        logic [7:0]  n;
        logic [15:0] data;
        logic [7:0]  flags;
        logic [7:0]  flip;
        logic        toggle;
        int          exp_x;
        int          exp_err;
        int          exp_cnt;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic fx2_frame_t make_frame(input logic [23:0] a, input logic [7:0] n,
                                              input logic [15:0] d, input logic [7:0] fl,
                                              input logic [7:0] flip);
        fx2_frame_t f;
        f[0] = a[7:0];
        f[1] = a[15:8];
        f[2] = a[23:16];
        f[3] = n;
        f[4] = d[7:0];
        f[5] = d[15:8];
        f[6] = fl;
        f[7] = a[7:0] ^ a[15:8] ^ a[23:16] ^ n ^ d[7:0] ^ d[15:8] ^ fl ^ flip;
        return f;
    endfunction

    task automatic send_bytes(input fx2_frame_t f, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            dav    = 1'b1;
            datain = f[i];
            @(negedge clk);
            if (!fifo_rd) rd_miss++;
            step();
        end
        dav = 1'b0;
    endtask

    // Entered in the cycle after the final byte; the first request must appear one cycle later
    task automatic collect(input string name, input logic [23:0] a0, input logic [15:0] d,
                           input logic rdwr, input logic cmd, input int exp_x,
                           input int exp_err, input logic toggle);
        int          nx;
        int          lat;
        int          nerr;
        int          bad;
        logic [23:0] ea;
        nx   = 0;
        lat  = -1;
        nerr = 0;
        bad  = 0;
        for (int c = 1; c <= 2 * exp_x + 10; c++) begin
            bus.req_ready = toggle ? ((c % 2) == 1) : 1'b1;
            @(negedge clk);
            if (frame_err) nerr++;
            if (bus.req_valid) begin
                if (lat < 0) lat = c;
                ea = a0 + 24'(nx);
                if (bus.req_addr !== ea || bus.req_data !== d ||
                    bus.req_rdwr !== rdwr || bus.req_cmd !== cmd) begin
                    bad++;
                    if (bad == 1)
                        $display("FAIL %s req fields: addr %h data %h rdwr %b cmd %b, expected %h %h %b %b",
                                 name, bus.req_addr, bus.req_data, bus.req_rdwr, bus.req_cmd,
                                 ea, d, rdwr, cmd);
                end
                if (bus.req_ready) nx++;
            end
            step();
        end
        bus.req_ready = 1'b0;
        check({name, " transfers"}, nx, exp_x);
        check({name, " latency"}, lat, (exp_x > 0) ? 2 : -1);
        check({name, " frame_err pulses"}, nerr, exp_err);
        check({name, " field errors"}, bad, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        fx2_frame_t f;
        fx2_frame_t g;
        int         early;
        int         stray;

        vecs[0] = '{24'h123456, 8'd0,   16'hBEEF, 8'h00, 8'h00, 1'b0, 1,   0, 0};
        vecs[1] = '{24'hFFFFFE, 8'd3,   16'h1234, 8'h01, 8'h00, 1'b1, 4,   0, 0};
        vecs[2] = '{24'h000100, 8'd1,   16'h5555, 8'h00, 8'h01, 1'b0, 0,   1, 1};
        vecs[3] = '{24'h000200, 8'd2,   16'hAAAA, 8'h01, 8'h00, 1'b0, 3,   0, 1};
        vecs[4] = '{24'h000001, 8'd7,   16'h0000, 8'h02, 8'h00, 1'b1, 1,   0, 1};
        vecs[5] = '{24'hABCDEF, 8'd255, 16'h0F0F, 8'h00, 8'h00, 1'b0, 256, 0, 1};

        bus.req_ready = 1'b0;
        rst = 1'b1;
        dav = 1'b1;
        step();
        step();
        @(negedge clk);
        check("reset fifo_rd", fifo_rd, 0);
        check("reset req_valid", bus.req_valid, 0);
        check("reset req_addr", bus.req_addr, 0);
        check("reset err_count", err_count, 0);
        check("reset frame_err", frame_err, 0);
        step();
        rst = 1'b0;
        dav = 1'b0;
        step();

        for (int i = 0; i < 6; i++) begin
            f = make_frame(vecs[i].addr, vecs[i].n, vecs[i].data, vecs[i].flags, vecs[i].flip);
            send_bytes(f, 0, 7);
            collect($sformatf("vec%0d", i), vecs[i].addr, vecs[i].data, vecs[i].flags[0],
                    vecs[i].flags[1], vecs[i].exp_x, vecs[i].exp_err, vecs[i].toggle);
            check($sformatf("vec%0d err_count", i), err_count, vecs[i].exp_cnt);
            step();
        end

        // Partial frame, 255 idle cycles, then a new frame whose first byte meets the timeout
        g = make_frame(24'h777777, 8'd5, 16'h9999, 8'h00, 8'h00);
        f = make_frame(24'h00C0DE, 8'd1, 16'h7777, 8'h00, 8'h00);
        send_bytes(g, 0, 2);
        early = 0;
        for (int c = 0; c < 255; c++) begin
            @(negedge clk);
            if (frame_err) early++;
            step();
        end
        check("timeout early frame_err", early, 0);
        dav    = 1'b1;
        datain = f[0];
        @(negedge clk);
        check("timeout frame_err", frame_err, 1);
        check("timeout fifo_rd", fifo_rd, 1);
        step();
        send_bytes(f, 1, 7);
        collect("after timeout", 24'h00C0DE, 16'h7777, 1'b0, 1'b0, 2, 0, 1'b0);
        check("timeout err_count", err_count, 2);
        step();

        // Reset landing on the second transfer of a 4-beat read burst
        f = make_frame(24'h000100, 8'd3, 16'h4242, 8'h01, 8'h00);
        send_bytes(f, 0, 7);
        bus.req_ready = 1'b1;
        step();
        step();
        @(negedge clk);
        check("pre-reset valid", bus.req_valid, 1);
        check("pre-reset addr", bus.req_addr, 24'h000101);
        rst = 1'b1;
        dav = 1'b1;
        #1;
        check("mid-burst reset valid", bus.req_valid, 0);
        check("mid-burst reset addr", bus.req_addr, 0);
        check("mid-burst reset data", bus.req_data, 0);
        check("mid-burst reset rdwr/cmd", {bus.req_rdwr, bus.req_cmd}, 0);
        check("mid-burst reset fifo_rd", fifo_rd, 0);
        check("mid-burst reset frame_err", frame_err, 0);
        check("mid-burst reset err_count", err_count, 0);
        step();
        step();
        rst = 1'b0;
        dav = 1'b0;
        stray = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.req_valid) stray++;
            step();
        end
        check("post-reset stray requests", stray, 0);
        bus.req_ready = 1'b0;
        f = make_frame(24'h345678, 8'd1, 16'hCAFE, 8'h00, 8'h00);
        send_bytes(f, 0, 7);
        collect("post-reset frame", 24'h345678, 16'hCAFE, 1'b0, 1'b0, 2, 0, 1'b1);
        check("post-reset err_count", err_count, 0);

        check("fifo_rd follows availability", rd_miss, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fx2_cmd_framer.md
FX2_CMD_FRAMER -- requirements
Module: fx2_cmd_framer

Interface
REQ-001 Parameter TIMEOUT_CYCLES, 255, idle cycles allowed between bytes of a partial frame before it is discarded.
REQ-002 clk  input  1  single clock, FX2 interface clock; all logic on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 fifo_data_available  input  1  positive-logic FIFO2 not-empty flag.
REQ-005 fifo_datain  input  8  FIFO2 data byte, valid while fifo_rd is high.
REQ-006 fifo_rd  output  1  positive-logic read strobe; one byte consumed per high cycle.
REQ-007 req_valid  output  1  memory request present.
REQ-008 req_ready  input  1  downstream SDRAM controller accepts the request.
REQ-009 req_addr  output  24  word address.
REQ-010 req_data  output  16  write data.
REQ-011 req_rdwr  output  1  1=read, 0=write.
REQ-012 req_cmd  output  1  1=precharge/loadmode command; addr[0] selects which.
REQ-013 frame_err  output  1  one-cycle pulse on a dropped frame.
REQ-014 err_count  output  8  saturating count of dropped frames.

Function
REQ-015 Frame = 8 bytes in order: addr[7:0], addr[15:8], addr[23:16], burst length N, data[7:0], data[15:8], flags (bit0 rdwr, bit1 cmd), checksum.
REQ-016 Checksum byte SHALL equal the XOR of bytes 0-6; on mismatch, drop the frame: no request, frame_err pulse, err_count+1 (saturate at 255).
REQ-017 States: COLLECT, CHECK, ISSUE.
- COLLECT: fifo_rd = fifo_data_available; capture byte into slot index 0-7 in the same cycle.
- After byte 7 is captured, go to CHECK.
REQ-018 CHECK lasts exactly one cycle. On a good checksum, go to ISSUE with req_valid high on the next cycle. On a bad checksum, pulse frame_err and return to COLLECT with byte index 0.
REQ-019 ISSUE, data frame: issue N+1 requests (N=0 means 1, N=255 means 256).
- req_addr starts at the frame address and increments by 1 per accepted request, wrapping modulo 2^24.
- req_data, req_rdwr and req_cmd stay constant for the whole burst.
REQ-020 ISSUE, cmd frame (flags bit1=1): exactly one request; N is ignored.
REQ-021 Handshake: a transfer occurs on a cycle where req_valid and req_ready are both high. While req_valid is high, all req_* outputs SHALL hold stable until that transfer. req_valid SHALL NOT depend combinationally on req_ready.
REQ-022 Back-to-back: the next burst request SHALL be valid in the cycle after a transfer (req_valid stays high). After the last transfer, return to COLLECT.
REQ-023 fifo_rd SHALL be low in CHECK and ISSUE; the upstream FIFO backpressures.
REQ-024 Timeout: in COLLECT with byte index not 0, count consecutive cycles with no byte read. When the count reaches TIMEOUT_CYCLES, discard the partial frame, pulse frame_err, increment err_count and reset the index to 0. Any byte read clears the count.
REQ-025 A byte arriving in the same cycle the timeout fires SHALL be treated as byte 0 of a new frame.
REQ-026 Minimum latency: 8th byte read at cycle T, then CHECK at T+1, then req_valid high at T+2.

Reset
REQ-027 rst high SHALL force the following, immediately and at any point mid-frame or mid-burst: state COLLECT, index 0, timeout count 0, fifo_rd 0, req_valid 0, req_addr 0, req_data 0, req_rdwr 0, req_cmd 0, frame_err 0, err_count 0.
REQ-028 After rst falls, the first frame SHALL be accepted normally; partial data from before reset is never issued.

Structure
REQ-029 Shared package (fx2_pkg) SHALL hold:
- the state enum;
- frame byte offsets (ADDR0..CSUM = 0..7);
- flag bit positions FLAG_RDWR=0, FLAG_CMD=1;
- FRAME_BYTES=8.
REQ-030 One sub-module is natural: fx2_byte_timer, the TIMEOUT_CYCLES idle-gap counter with clear, enable and expire outputs.

Verification
REQ-031 Write frame addr 0x123456, N=0, data 0xBEEF, flags 0x00, valid checksum, req_ready=1 -> exactly one transfer with addr 0x123456, data 0xBEEF, rdwr 0, at T+2.
REQ-032 Read frame addr 0xFFFFFE, N=3, req_ready toggled 1/0 -> four transfers with addrs FFFFFE, FFFFFF, 000000, 000001; outputs stable while stalled.
REQ-033 Frame with checksum XOR-ed with 0x01 -> no req_valid, one frame_err pulse, err_count=1; the following good frame is issued normally.
REQ-034 Three bytes, then fifo_data_available low for 255 cycles -> frame_err on the expiry cycle, then a fresh 8-byte frame issues correctly.
REQ-035 Cmd frame flags 0x02, addr 0x000001, N=7 -> exactly one transfer with req_cmd=1, addr[0]=1.
REQ-036 rst asserted during the 2nd transfer of an N=3 burst -> all outputs reach their reset values immediately; no further transfers until a new frame completes.
